// File: rtl/snake_head_stepper.sv
// rtl/snake_head_stepper.sv - snake head position stepper with toroidal wrap
//
// Purpose: advances the snake head by one grid cell on each rising edge of
// the movement tick while enabled. Applies the latched direction request and
// wraps around the grid edges.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   tick       movement tick level from the speed divider
//   enable     1 = running, 0 = paused
//   btn_up/btn_down/btn_left/btn_right  debounced button levels
//   head_x     current head column (0..GRID_W-1)
//   head_y     current head row    (0..GRID_H-1)
//   dir        committed heading: 0 right, 1 down, 2 left, 3 up
//   step       one-cycle pulse when a new head position becomes visible
//   wrapped    one-cycle pulse with step when that move crossed an edge
//   step_cnt   moves since reset, free-running 16-bit count
module snake_head_stepper #(
  parameter int             GRID_W    = 32,
  parameter int             GRID_H    = 24,
  parameter int             X_W       = 6,
  parameter int             Y_W       = 5,
  parameter int             START_X   = 16,
  parameter int             START_Y   = 12,
  parameter logic [1:0]     START_DIR = 2'd0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           enable,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [1:0]     dir,
  output logic           step,
  output logic           wrapped,
  output logic [15:0]    step_cnt
);

  localparam logic [X_W-1:0] X_MAX   = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX   = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0] X_START = X_W'(START_X);
  localparam logic [Y_W-1:0] Y_START = Y_W'(START_Y);

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  logic           tick_q;
  logic [1:0]     pend_dir;
  logic           move;
  logic           req_valid;
  logic [1:0]     req_dir;
  logic           req_ok;
  logic [X_W-1:0] next_x;
  logic [Y_W-1:0] next_y;
  logic           next_wrap;

  // Rising edge of tick only; a held tick produces a single move.
  assign move = tick & ~tick_q & enable;

  // Button request with priority up > down > left > right.
  always_comb begin
    req_valid = btn_up | btn_down | btn_left | btn_right;
    if (btn_up)
      req_dir = DIR_UP;
    else if (btn_down)
      req_dir = DIR_DOWN;
    else if (btn_left)
      req_dir = DIR_LEFT;
    else
      req_dir = DIR_RIGHT;
  end

  // Opposite headings differ only in bit 1. The check is against the
  // committed heading so two quick presses can never reverse the snake.
  assign req_ok = req_valid & (req_dir != (dir ^ 2'd2));

  // Candidate next position for a move in pend_dir, wrapping on the
  // parameterised grid bounds rather than the register width.
  always_comb begin
    next_x    = head_x;
    next_y    = head_y;
    next_wrap = 1'b0;
    case (pend_dir)
      DIR_RIGHT: begin
        if (head_x == X_MAX) begin
          next_x    = '0;
          next_wrap = 1'b1;
        end else begin
          next_x = head_x + X_W'(1);
        end
      end
      DIR_DOWN: begin
        if (head_y == Y_MAX) begin
          next_y    = '0;
          next_wrap = 1'b1;
        end else begin
          next_y = head_y + Y_W'(1);
        end
      end
      DIR_LEFT: begin
        if (head_x == '0) begin
          next_x    = X_MAX;
          next_wrap = 1'b1;
        end else begin
          next_x = head_x - X_W'(1);
        end
      end
      default: begin
        if (head_y == '0) begin
          next_y    = Y_MAX;
          next_wrap = 1'b1;
        end else begin
          next_y = head_y - Y_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_x   <= X_START;
      head_y   <= Y_START;
      dir      <= START_DIR;
      pend_dir <= START_DIR;
      tick_q   <= 1'b0;
      step     <= 1'b0;
      wrapped  <= 1'b0;
      step_cnt <= 16'd0;
    end else begin
      // tick_q tracks tick even while paused so resuming mid-tick is inert.
      tick_q  <= tick;
      step    <= move;
      wrapped <= move & next_wrap;
      if (req_ok)
        pend_dir <= req_dir;
      if (move) begin
        head_x   <= next_x;
        head_y   <= next_y;
        dir      <= pend_dir;
        step_cnt <= step_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_snake_head_stepper.sv
// tb/tb_snake_head_stepper.sv - self-checking bench for snake_head_stepper
module tb_snake_head_stepper;

  localparam int GW = 32;
  localparam int GH = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        enable = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [5:0]  head_x;
  logic [4:0]  head_y;
  logic [1:0]  dir;
  logic        step;
  logic        wrapped;
  logic [15:0] step_cnt;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  int m_x, m_y, m_dir, m_pend, m_tickq, m_step, m_wrap, m_cnt;

  always #5 clk = ~clk;

  snake_head_stepper dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .head_x(head_x), .head_y(head_y), .dir(dir), .step(step),
    .wrapped(wrapped), .step_cnt(step_cnt)
  );

  typedef struct {
    logic rst, tk, en, u, d, l, r;
    int   ex, ey, edir, estep, ewrap, ecnt;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one clock edge with the given sampled inputs.
  task automatic model_edge(input logic rst, tk, en, u, d, l, r);
    int ux, uy, req, old_dir;
    if (!rst) begin
      m_x = 16; m_y = 12; m_dir = 0; m_pend = 0;
      m_tickq = 0; m_step = 0; m_wrap = 0; m_cnt = 0;
      return;
    end
    old_dir = m_dir;
    if (tk && !m_tickq && en) begin
      ux = m_x + ((m_pend == 0) ? 1 : (m_pend == 2) ? -1 : 0);
      uy = m_y + ((m_pend == 1) ? 1 : (m_pend == 3) ? -1 : 0);
      m_wrap = (ux < 0 || ux >= GW || uy < 0 || uy >= GH) ? 1 : 0;
      m_x = (ux + GW) % GW;
      m_y = (uy + GH) % GH;
      m_dir = m_pend;
      m_cnt = (m_cnt + 1) % 65536;
      m_step = 1;
    end else begin
      m_step = 0;
      m_wrap = 0;
    end
    if (u || d || l || r) begin
      req = u ? 3 : d ? 1 : l ? 2 : 0;
      if (req != (old_dir + 2) % 4)
        m_pend = req;
    end
    m_tickq = tk ? 1 : 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".head_x"}, int'(head_x), m_x);
    check({tag, ".head_y"}, int'(head_y), m_y);
    check({tag, ".dir"}, int'(dir), m_dir);
    check({tag, ".step"}, int'(step), m_step);
    check({tag, ".wrapped"}, int'(wrapped), m_wrap);
    check({tag, ".step_cnt"}, int'(step_cnt), m_cnt);
  endtask

  // Drive inputs (called at a negedge), clock once, check against the model.
  task automatic apply(input string tag, input logic rst, tk, en, u, d, l, r);
    rst_n = rst; tick = tk; enable = en;
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    @(posedge clk);
    model_edge(rst, tk, en, u, d, l, r);
    #1;
    check_model(tag);
    @(negedge clk);
  endtask

  task automatic move_once(input string tag);
    apply(tag, 1, 1, 1, 0, 0, 0, 0);
    apply(tag, 1, 0, 1, 0, 0, 0, 0);
  endtask

  int cnt_before, y_before;

  initial begin
    //            rst tk en u d l r   x   y dir stp wr cnt
    vecs[0]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 16, 12, 0, 0, 0, 0};
    vecs[1]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 17, 12, 0, 1, 0, 1};
    vecs[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 17, 12, 0, 0, 0, 1};
    vecs[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 18, 12, 0, 1, 0, 2};
    vecs[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 18, 12, 0, 0, 0, 2};
    vecs[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 19, 12, 0, 1, 0, 3};
    vecs[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 19, 12, 0, 0, 0, 3};
    vecs[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 19, 12, 0, 0, 0, 3};
    vecs[8]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 20, 12, 0, 1, 0, 4};
    vecs[9]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 20, 12, 0, 0, 0, 4};
    vecs[10] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 20, 12, 0, 0, 0, 4};
    vecs[11] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 20, 11, 3, 1, 0, 5};
    vecs[12] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 20, 11, 3, 0, 0, 5};
    vecs[13] = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 20, 10, 3, 1, 0, 6};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      rst_n = vecs[i].rst; tick = vecs[i].tk; enable = vecs[i].en;
      btn_up = vecs[i].u; btn_down = vecs[i].d;
      btn_left = vecs[i].l; btn_right = vecs[i].r;
      @(posedge clk);
      model_edge(vecs[i].rst, vecs[i].tk, vecs[i].en, vecs[i].u, vecs[i].d,
                 vecs[i].l, vecs[i].r);
      #1;
      check($sformatf("vec%0d.head_x", i), int'(head_x), vecs[i].ex);
      check($sformatf("vec%0d.head_y", i), int'(head_y), vecs[i].ey);
      check($sformatf("vec%0d.dir", i), int'(dir), vecs[i].edir);
      check($sformatf("vec%0d.step", i), int'(step), vecs[i].estep);
      check($sformatf("vec%0d.wrapped", i), int'(wrapped), vecs[i].ewrap);
      check($sformatf("vec%0d.step_cnt", i), int'(step_cnt), vecs[i].ecnt);
      @(negedge clk);
    end

    // Right-edge wrap from (31,5), then turn up.
    apply("wr_rst", 0, 0, 1, 0, 0, 0, 0);
    apply("wr_up", 1, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) move_once("wr_mv_up");
    apply("wr_right", 1, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) move_once("wr_mv_right");
    check("wr_pre_x", int'(head_x), 31);
    check("wr_pre_y", int'(head_y), 5);
    apply("wr_tick", 1, 1, 1, 0, 0, 0, 0);
    check("wr_x", int'(head_x), 0);
    check("wr_y", int'(head_y), 5);
    check("wr_wrapped", int'(wrapped), 1);
    check("wr_step", int'(step), 1);
    apply("wr_lo", 1, 0, 1, 1, 0, 0, 0);
    apply("wr_tick2", 1, 1, 1, 0, 0, 0, 0);
    check("up_x", int'(head_x), 0);
    check("up_y", int'(head_y), 4);
    check("up_dir", int'(dir), 3);
    check("up_wrapped", int'(wrapped), 0);
    apply("wr_lo2", 1, 0, 1, 0, 0, 0, 0);

    // Turn left, then up+right together: up wins.
    apply("pr_left", 1, 0, 1, 0, 0, 1, 0);
    move_once("pr_mv_left");
    check("pr_dir_left", int'(dir), 2);
    apply("pr_btns", 1, 0, 1, 1, 0, 0, 1);
    apply("pr_tick", 1, 1, 1, 0, 0, 0, 0);
    check("pr_dir_up", int'(dir), 3);
    apply("pr_lo", 1, 0, 1, 0, 0, 0, 0);

    // Tick held 5 cycles: exactly one move.
    cnt_before = int'(step_cnt);
    for (int i = 0; i < 5; i++) apply("hold", 1, 1, 1, 0, 0, 0, 0);
    apply("hold_lo", 1, 0, 1, 0, 0, 0, 0);
    check("hold_cnt", int'(step_cnt), (cnt_before + 1) % 65536);

    // Head right, then pause with ticks and btn_down.
    apply("pa_right", 1, 0, 1, 0, 0, 0, 1);
    move_once("pa_mv_right");
    y_before = int'(head_y);
    cnt_before = int'(step_cnt);
    for (int i = 0; i < 4; i++) begin
      apply("pa_tick", 1, 1, 0, 0, 1, 0, 0);
      check("pa_step", int'(step), 0);
      apply("pa_lo", 1, 0, 0, 0, 1, 0, 0);
      check("pa_step", int'(step), 0);
    end
    apply("pa_hi", 1, 1, 0, 0, 0, 0, 0);
    apply("pa_resume", 1, 1, 1, 0, 0, 0, 0);
    check("pa_resume_step", int'(step), 0);
    check("pa_cnt", int'(step_cnt), cnt_before);
    apply("pa_lo2", 1, 0, 1, 0, 0, 0, 0);
    apply("pa_tick2", 1, 1, 1, 0, 0, 0, 0);
    check("pa_down_y", int'(head_y), (y_before + 1) % GH);
    check("pa_down_dir", int'(dir), 1);
    apply("pa_lo3", 1, 0, 1, 0, 0, 0, 0);

    // Reset on the same edge as a tick.
    apply("rs_tick", 0, 1, 1, 0, 0, 0, 0);
    check("rs_x", int'(head_x), 16);
    check("rs_y", int'(head_y), 12);
    check("rs_dir", int'(dir), 0);
    check("rs_step", int'(step), 0);
    check("rs_cnt", int'(step_cnt), 0);
    // Tick already high on the first cycle after release moves.
    apply("rs_first", 1, 1, 1, 0, 0, 0, 0);
    check("rs_first_x", int'(head_x), 17);
    apply("rs_lo", 1, 0, 1, 0, 0, 0, 0);

    // step_cnt rollover.
    force dut.step_cnt = 16'hFFFF;
    #1;
    release dut.step_cnt;
    m_cnt = 65535;
    #1;
    apply("roll_tick", 1, 1, 1, 0, 0, 0, 0);
    check("roll_cnt", int'(step_cnt), 0);
    apply("roll_lo", 1, 0, 1, 0, 0, 0, 0);

    // Randomised stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_tk, r_en, r_u, r_d, r_l, r_r;
      r_rst = ($urandom_range(0, 99) != 0);
      r_tk  = $urandom_range(0, 1);
      r_en  = ($urandom_range(0, 7) != 0);
      r_u   = ($urandom_range(0, 5) == 0);
      r_d   = ($urandom_range(0, 5) == 0);
      r_l   = ($urandom_range(0, 5) == 0);
      r_r   = ($urandom_range(0, 5) == 0);
      apply("rand", r_rst, r_tk, r_en, r_u, r_d, r_l, r_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
